// File: rtl/dino_pkg.sv
// Shared constants and state encoding for the cloud sequencing logic.
package dino_pkg;

  localparam int NUM_SLOTS = 3;

  localparam logic [6:0] CLOUD_H     = 7'd18;
  localparam logic [9:0] CLOUD_W     = 10'd100;
  localparam logic [9:0] SCREEN_W    = 10'd800;
  localparam logic [9:0] MIN_GAP     = 10'd150;
  localparam logic [9:0] FIRST_DELAY = 10'd50;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_PICK   = 2'd1,
    S_LAUNCH = 2'd2
  } state_t;

endpackage

// File: rtl/slot_picker.sv
// Lowest-index idle slot priority encoder.
module slot_picker
  import dino_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] i_active,
  output logic                 o_valid,
  output logic [NUM_SLOTS-1:0] o_onehot
);

  // Pick the first slot whose busy flag is clear; valid when any is free.
  always_comb begin
    o_onehot = '0;
    o_valid  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!o_valid && !i_active[i]) begin
        o_onehot[i] = 1'b1;
        o_valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cloud_scheduler.sv
// Cloud launch sequencer: timing between launches, slot choice, height choice
// and the per-tick scroll step handed to the cloud renderer.
//
// state    | meaning
// S_WAIT   | counting ticks until the current interval has elapsed
// S_PICK   | waiting for an idle slot; latches slot and height
// S_LAUNCH | emits the one-tick launch pulse and draws the next interval
module cloud_scheduler
  import dino_pkg::*;
(
  input  logic       clk_100,
  input  logic       rst,
  input  logic       is_living,
  input  logic [3:0] move_rate,
  input  logic [4:0] random_five,
  input  logic [2:0] random_three,
  input  logic [2:0] slot_done,
  output logic [2:0] launch,
  output logic [6:0] launch_height,
  output logic [2:0] active,
  output logic [3:0] step
);

  state_t     r_state;
  logic [9:0] r_wait_cnt;
  logic [9:0] r_interval;
  logic [6:0] r_last_height;
  logic [6:0] r_cand_height;
  logic [2:0] r_sel;
  logic       r_first;
  logic [2:0] r_launch;
  logic [6:0] r_launch_height;
  logic [2:0] r_active;
  logic [3:0] r_step;

  logic       w_valid;
  logic [2:0] w_onehot;
  logic [6:0] w_cand;
  logic [6:0] w_diff;
  logic [6:0] w_height;
  logic [2:0] w_set;
  logic [9:0] w_next_interval;
  logic       w_unused;

  assign w_unused = move_rate[0];

  // Picker sees the registered busy flags, so a slot freed this tick is
  // only eligible from the next tick on.
  slot_picker u_slot_picker (
    .i_active (r_active),
    .o_valid  (w_valid),
    .o_onehot (w_onehot)
  );

  assign w_cand = {random_five, 2'b00};
  assign w_diff = (w_cand > r_last_height) ? (w_cand - r_last_height)
                                           : (r_last_height - w_cand);
  // Flipping bit 6 moves the cloud by 64 px and keeps the result <= 124.
  assign w_height = (!r_first && (w_diff < CLOUD_H)) ? (w_cand ^ 7'd64) : w_cand;

  assign w_next_interval = MIN_GAP + {2'b00, random_five, 3'b000}
                                   + {5'b00000, random_three, 2'b00};

  assign w_set = (r_state == S_LAUNCH) ? r_sel : 3'b000;

  // Sequencer, slot bookkeeping and step register; everything freezes while
  // the dino is dead except the launch pulse, which is forced low.
  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      r_state         <= S_WAIT;
      r_wait_cnt      <= '0;
      r_interval      <= FIRST_DELAY;
      r_last_height   <= '0;
      r_cand_height   <= '0;
      r_sel           <= '0;
      r_first         <= 1'b1;
      r_launch        <= '0;
      r_launch_height <= '0;
      r_active        <= '0;
      r_step          <= '0;
    end else if (!is_living) begin
      r_launch <= '0;
    end else begin
      r_step   <= {1'b0, move_rate[3:1]};
      r_launch <= '0;
      r_active <= (r_active & ~slot_done) | w_set;
      case (r_state)
        S_WAIT: begin
          if (r_wait_cnt >= r_interval - 10'd1) begin
            r_wait_cnt <= '0;
            r_state    <= S_PICK;
          end else begin
            r_wait_cnt <= r_wait_cnt + 10'd1;
          end
        end
        S_PICK: begin
          if (w_valid) begin
            r_sel         <= w_onehot;
            r_cand_height <= w_height;
            r_state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_launch        <= r_sel;
          r_launch_height <= r_cand_height;
          r_last_height   <= r_cand_height;
          r_first         <= 1'b0;
          r_interval      <= w_next_interval;
          r_state         <= S_WAIT;
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  assign launch        = r_launch;
  assign launch_height = r_launch_height;
  assign active        = r_active;
  assign step          = r_step;

endmodule

// File: tb/tb_cloud_scheduler.sv
// Directed testbench for cloud_scheduler.
module tb_cloud_scheduler;

  logic       clk_100 = 1'b0;
  logic       rst = 1'b1;
  logic       is_living = 1'b1;
  logic [3:0] move_rate = 4'd6;
  logic [4:0] random_five = '0;
  logic [2:0] random_three = '0;
  logic [2:0] slot_done = '0;
  logic [2:0] launch;
  logic [6:0] launch_height;
  logic [2:0] active;
  logic [3:0] step;

  int n_cmp = 0;
  int n_bad = 0;

  cloud_scheduler dut (
    .clk_100       (clk_100),
    .rst           (rst),
    .is_living     (is_living),
    .move_rate     (move_rate),
    .random_five   (random_five),
    .random_three  (random_three),
    .slot_done     (slot_done),
    .launch        (launch),
    .launch_height (launch_height),
    .active        (active),
    .step          (step)
  );

  always #5 clk_100 = ~clk_100;

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic do_reset(input logic [4:0] rf, input logic [2:0] rt);
    rst = 1'b1;
    is_living = 1'b1;
    move_rate = 4'd6;
    random_five = rf;
    random_three = rt;
    slot_done = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Ticks until launch goes nonzero; n is the tick count, -1 on timeout.
  task automatic wait_launch(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (launch !== 3'b000) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++; if (launch !== 3'b000) begin n_bad++; $display("FAIL reset_launch got %b want %b", launch, 3'b000); end
    n_cmp++; if (launch_height !== 7'd0) begin n_bad++; $display("FAIL reset_height got %0d want 0", launch_height); end
    n_cmp++; if (active !== 3'b000) begin n_bad++; $display("FAIL reset_active got %b want %b", active, 3'b000); end
    n_cmp++; if (step !== 4'd0) begin n_bad++; $display("FAIL reset_step got %0d want 0", step); end
  endtask

  task automatic test_first_launch();
    int n;
    do_reset(5'd0, 3'd0);
    wait_launch(600, n);
    n_cmp++; if (n !== 52) begin n_bad++; $display("FAIL first_tick got %0d want 52", n); end
    n_cmp++; if (launch !== 3'b001) begin n_bad++; $display("FAIL first_slot got %b want 001", launch); end
    n_cmp++; if (launch_height !== 7'd0) begin n_bad++; $display("FAIL first_height got %0d want 0", launch_height); end
    n_cmp++; if (step !== 4'd3) begin n_bad++; $display("FAIL first_step got %0d want 3", step); end
    n_cmp++; if (active !== 3'b001) begin n_bad++; $display("FAIL first_active got %b want 001", active); end
    wait_launch(600, n);
    n_cmp++; if (n !== 152) begin n_bad++; $display("FAIL second_gap got %0d want 152", n); end
    n_cmp++; if (launch !== 3'b010) begin n_bad++; $display("FAIL second_slot got %b want 010", launch); end
    n_cmp++; if (launch_height !== 7'd64) begin n_bad++; $display("FAIL second_height got %0d want 64", launch_height); end
    tick();
    n_cmp++; if (launch !== 3'b000) begin n_bad++; $display("FAIL pulse_width got %b want 000", launch); end
  endtask

  // Continues from test_first_launch: fill the last slot, then starve.
  task automatic test_all_busy();
    int n;
    int seen;
    wait_launch(600, n);
    n_cmp++; if (n !== 151) begin n_bad++; $display("FAIL third_gap got %0d want 151", n); end
    n_cmp++; if (launch !== 3'b100) begin n_bad++; $display("FAIL third_slot got %b want 100", launch); end
    n_cmp++; if (launch_height !== 7'd0) begin n_bad++; $display("FAIL third_height got %0d want 0", launch_height); end
    n_cmp++; if (active !== 3'b111) begin n_bad++; $display("FAIL full_active got %b want 111", active); end
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (launch !== 3'b000) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL starved_launches got %0d want 0", seen); end
    slot_done = 3'b100;
    tick();
    slot_done = 3'b000;
    n_cmp++; if (active !== 3'b011) begin n_bad++; $display("FAIL done_clear got %b want 011", active); end
    wait_launch(10, n);
    n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL done_to_launch got %0d want 2", n); end
    n_cmp++; if (launch !== 3'b100) begin n_bad++; $display("FAIL refill_slot got %b want 100", launch); end
    n_cmp++; if (active !== 3'b111) begin n_bad++; $display("FAIL refill_active got %b want 111", active); end
  endtask

  task automatic test_pause();
    int n;
    do_reset(5'd0, 3'd0);
    wait_launch(600, n);
    n_cmp++; if (n !== 52) begin n_bad++; $display("FAIL pause_first got %0d want 52", n); end
    for (int i = 0; i < 50; i++) tick();
    is_living = 1'b0;
    move_rate = 4'd10;
    slot_done = 3'b001;
    tick();
    slot_done = 3'b000;
    for (int i = 0; i < 99; i++) tick();
    n_cmp++; if (active !== 3'b001) begin n_bad++; $display("FAIL pause_active got %b want 001", active); end
    n_cmp++; if (step !== 4'd3) begin n_bad++; $display("FAIL pause_step got %0d want 3", step); end
    is_living = 1'b1;
    wait_launch(600, n);
    n_cmp++; if (n !== 102) begin n_bad++; $display("FAIL pause_resume got %0d want 102", n); end
    n_cmp++; if (launch !== 3'b010) begin n_bad++; $display("FAIL pause_slot got %b want 010", launch); end
    n_cmp++; if (step !== 4'd5) begin n_bad++; $display("FAIL resume_step got %0d want 5", step); end
  endtask

  task automatic test_height();
    int n;
    do_reset(5'd10, 3'd0);
    wait_launch(600, n);
    n_cmp++; if (launch_height !== 7'd40) begin n_bad++; $display("FAIL height_first got %0d want 40", launch_height); end
    random_five = 5'd12;
    wait_launch(600, n);
    n_cmp++; if (n !== 232) begin n_bad++; $display("FAIL height_gap1 got %0d want 232", n); end
    n_cmp++; if (launch_height !== 7'd112) begin n_bad++; $display("FAIL height_close got %0d want 112", launch_height); end
    random_five = 5'd20;
    wait_launch(600, n);
    n_cmp++; if (n !== 248) begin n_bad++; $display("FAIL height_gap2 got %0d want 248", n); end
    n_cmp++; if (launch_height !== 7'd80) begin n_bad++; $display("FAIL height_far got %0d want 80", launch_height); end
  endtask

  task automatic test_max_interval();
    int n;
    do_reset(5'd31, 3'd7);
    wait_launch(600, n);
    n_cmp++; if (launch_height !== 7'd124) begin n_bad++; $display("FAIL max_first_height got %0d want 124", launch_height); end
    wait_launch(600, n);
    n_cmp++; if (n !== 428) begin n_bad++; $display("FAIL max_gap got %0d want 428", n); end
    n_cmp++; if (launch_height !== 7'd60) begin n_bad++; $display("FAIL max_height got %0d want 60", launch_height); end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    do_reset(5'd0, 3'd0);
    seen = 0;
    for (int i = 0; i < 51; i++) begin
      tick();
      if (launch !== 3'b000) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_early got %0d want 0", seen); end
    rst = 1'b1;
    tick();
    n_cmp++; if (launch !== 3'b000) begin n_bad++; $display("FAIL mid_launch got %b want 000", launch); end
    n_cmp++; if (active !== 3'b000) begin n_bad++; $display("FAIL mid_active got %b want 000", active); end
    rst = 1'b0;
    wait_launch(600, n);
    n_cmp++; if (n !== 52) begin n_bad++; $display("FAIL mid_restart got %0d want 52", n); end
    n_cmp++; if (launch !== 3'b001) begin n_bad++; $display("FAIL mid_slot got %b want 001", launch); end
  endtask

  initial begin
    test_reset();
    test_first_launch();
    test_all_busy();
    test_pause();
    test_height();
    test_max_interval();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
